// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - control FSM sequencing the multicycle mult/div unit in execute
//
// Purpose: decodes mul/div R-type instructions, pulses the unit's start strobe,
// stalls the pipeline until the unit answers, then issues one register-file
// writeback (rd for a result, r30 for an exception).
//
// Optional build macro: MD_TIMEOUT_EN (WAIT gives up after TIMEOUT_CYC cycles
// and writes a forced exception code; otherwise WAIT waits indefinitely).
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   instr_valid   in   execute-stage instruction valid
//   opcode[4:0]   in   instruction opcode
//   aluop[4:0]    in   R-type ALU op field
//   rd[4:0]       in   destination register
//   flush         in   squash the in-flight mul/div
//   md_resultRDY  in   unit result valid (one-cycle pulse)
//   md_exception  in   unit exception, qualified by md_resultRDY
//   md_result     in   unit result [31:0]
//   ctrl_MULT     out  one-cycle start-multiply strobe
//   ctrl_DIV      out  one-cycle start-divide strobe
//   stall         out  freeze PC, F/D and D/X
//   wb_en         out  register-file write enable
//   wb_reg[4:0]   out  writeback register number
//   wb_data[31:0] out  writeback data
//   busy          out  FSM not IDLE

module multdiv_sequencer #(
  parameter int TIMEOUT_CYC = 40,
  parameter int CNT_W       = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [4:0]  opcode,
  input  logic [4:0]  aluop,
  input  logic [4:0]  rd,
  input  logic        flush,
  input  logic        md_resultRDY,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_WB,
    S_DRAIN
  } state_t;

  localparam logic [4:0] OP_RTYPE   = 5'b00000;
  localparam logic [4:0] ALU_MUL    = 5'b00110;
  localparam logic [4:0] ALU_DIV    = 5'b00111;
  localparam logic [4:0] REG_STATUS = 5'd30;

  // Counter must be able to represent the timeout value.
  if ((2 ** CNT_W) <= TIMEOUT_CYC) begin : g_cnt_w_too_small
  end

  state_t      state_q, state_d;
  logic        is_div_q;
  logic [4:0]  rd_q;
  logic [31:0] result_q;
  logic        exc_q;

  logic        md_op;
  logic        op_is_div;

  assign op_is_div = (aluop == ALU_DIV);
  assign md_op     = instr_valid && (opcode == OP_RTYPE) &&
                     ((aluop == ALU_MUL) || (aluop == ALU_DIV));

`ifdef MD_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_hit;
  logic             to_drain_q;

  // cnt_q holds the number of completed WAIT cycles, so this fires in the
  // TIMEOUT_CYC-th WAIT cycle.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state_q == S_START) begin
      cnt_q <= '0;
    end else if (state_q == S_WAIT && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    stall     = 1'b0;
    wb_en     = 1'b0;
    wb_reg    = 5'd0;
    wb_data   = 32'd0;
    busy      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        // Stall combinationally so the instruction stays in D/X; a same-cycle
        // flush squashes it before it starts. Gated by reset so every output
        // is low while reset is held.
        if (md_op && !flush && reset) begin
          stall   = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        ctrl_MULT = ~is_div_q;
        ctrl_DIV  = is_div_q;
        stall     = 1'b1;
        state_d   = flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (flush) begin
          // A result arriving with the flush is simply dropped; otherwise
          // the unit still owes us one result that must be absorbed.
          state_d = md_resultRDY ? S_IDLE : S_DRAIN;
        end else if (md_resultRDY) begin
          state_d = S_WB;
        end
`ifdef MD_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = S_WB;
        end
`endif
      end
      S_WB: begin
        if (exc_q) begin
          wb_en   = 1'b1;
          wb_reg  = REG_STATUS;
          wb_data = {29'd0, (is_div_q ? 3'd5 : 3'd4)};
        end else if (rd_q != 5'd0) begin
          wb_en   = 1'b1;
          wb_reg  = rd_q;
          wb_data = result_q;
        end
`ifdef MD_TIMEOUT_EN
        state_d = to_drain_q ? S_DRAIN : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      S_DRAIN: begin
        // A new mul/div waits here; it is accepted once IDLE is reached.
        stall = md_op && !flush;
        if (md_resultRDY) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      rd_q     <= 5'd0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && state_d == S_START) begin
        is_div_q <= op_is_div;
        rd_q     <= rd;
      end
      if (state_q == S_WAIT && md_resultRDY && !flush) begin
        result_q <= md_result;
        exc_q    <= md_exception;
      end
`ifdef MD_TIMEOUT_EN
      else if (state_q == S_WAIT && timeout_hit && !flush) begin
        exc_q <= 1'b1;
      end
`endif
    end
  end

`ifdef MD_TIMEOUT_EN
  // Remembers that WB was forced, so the late unit result gets drained.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_drain_q <= 1'b0;
    end else if (state_q == S_START) begin
      to_drain_q <= 1'b0;
    end else if (state_q == S_WAIT && !md_resultRDY && !flush && timeout_hit) begin
      to_drain_q <= 1'b1;
    end
  end
`endif

endmodule
